sync_filter_bank: RTL
=====================

Name: sync_filter_bank

Overview:
Multi-channel, parametrised-depth synchroniser for bringing asynchronous level signals into the `clk` domain. Examples are external status lines and slow cross-domain flags. Each channel has a configurable flop chain, then a stability (glitch) filter, then edge detection. It succeeds the fixed two-flop synchroniser in the pipelined CPU's async-FIFO area and adds per-channel filtering and edge pulses.

Parameters:
- CHANNELS, 4: number of independent 1-bit channels. Must be >= 1.
- STAGES, 2: synchroniser flops per channel. Must be >= 2.
- FILTER_CYCLES, 3: consecutive cycles a new synchronised value must hold before `sync_out` accepts it. Must be >= 1; a value of 1 means no filtering.
- RESET_VALUE, {CHANNELS{1'b0}}: per-channel reset level of chain flops and `sync_out`.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- async_in  in  CHANNELS  asynchronous level inputs, one bit per channel.
- sync_out  out  CHANNELS  filtered, synchronised levels.
- rise_pulse  out  CHANNELS  one-cycle pulse when `sync_out[i]` goes 0->1.
- fall_pulse  out  CHANNELS  one-cycle pulse when `sync_out[i]` goes 1->0.
- any_change  out  1  registered OR of all rise and fall pulses, coincident with them.

Behaviour:
- Reset (async assert, sync use after deassert):
  - every chain flop of channel i = RESET_VALUE[i];
  - sync_out = RESET_VALUE;
  - filter counters = 0;
  - rise_pulse = 0, fall_pulse = 0, any_change = 0.
- No spurious edge pulse may appear after reset release when async_in equals RESET_VALUE.
- Chain: stage[0] <= async_in[i]; stage[k] <= stage[k-1]. The synchronised sample is s[i] = stage[STAGES-1].
- Filter, per channel, with counter cnt of width $clog2(FILTER_CYCLES), minimum 1 bit:
  - if s == sync_out: cnt <= 0.
  - else if cnt == FILTER_CYCLES-1: sync_out <= s, cnt <= 0.
  - else: cnt <= cnt+1.
- Latency: take an input change that is stable before edge E0 and held. `sync_out` changes at edge E0+STAGES+FILTER_CYCLES-1. With the defaults this is E0+4.
- Glitch rejection: a sample s that differs from `sync_out` for fewer than FILTER_CYCLES consecutive cycles never reaches `sync_out`. The counter returns to 0 on the first matching cycle; partial counts are never carried over.
- Edge pulses are registered and asserted at the same edge `sync_out` changes. They are high for exactly one cycle.
  - rise_pulse[i] = new value 1; fall_pulse[i] = new value 0.
  - At most one of rise_pulse[i] or fall_pulse[i] is high per cycle. Minimum spacing between two pulses on one channel is FILTER_CYCLES cycles.
- any_change is registered alongside the pulses: high iff any rise or fall pulse is high in that cycle.
- Simultaneous changes on several channels are handled independently; any_change is a single pulse.
- Reset mid-filter or mid-pulse:
  - all counters and pulses clear immediately;
  - sync_out returns to RESET_VALUE without generating a pulse.
- Metastability: there is no X-propagation requirement beyond stage[0]. All stage flops carry a synthesis keep/ASYNC_REG attribute.

Decomposition:
- Shared package sync_pkg holds:
  - the parameter legality limits MIN_STAGES=2 and MIN_FILTER=1, enforced with elaboration-time checks;
  - a function cnt_width(FILTER_CYCLES).
- Sub-module sync_filter_channel covers one channel: chain, filter counter and edge register. The top generates CHANNELS instances and the any_change OR register.

Test Plan:
1. Reset release with async_in=RESET_VALUE=4'b0000, defaults, idle 20 cycles -> sync_out=0; no rise_pulse, fall_pulse or any_change at any time.
2. Step async_in[0] 0->1 before edge E0, held -> sync_out[0]=1 from edge E0+4; rise_pulse[0] and any_change high exactly in cycle E0+4..E0+5; other channels unchanged.
3. Glitch: async_in[1]=1 for 2 cycles then 0 (FILTER_CYCLES=3) -> sync_out[1] stays 0; no pulses. Repeat with a 3-cycle-wide high -> sync_out[1] rises once, then falls 3 cycles after the sample returns to 0, with one fall_pulse.
4. Simultaneous step on all 4 channels -> rise_pulse=4'b1111 in one cycle; any_change is a single 1-cycle pulse.
5. Assert reset mid-filter (cnt=1) and during a pulse cycle -> outputs clear asynchronously within the reset cycle. After release with async_in=0, no pulse.
6. Parameter sweep STAGES in {2,3,5}, FILTER_CYCLES in {1,4}, RESET_VALUE=4'b1010 -> measured latency = STAGES+FILTER_CYCLES-1. Post-reset sync_out=4'b1010 with no pulses when async_in=4'b1010.

Source files
------------

// File: rtl/sync_filter_bank_pkg.sv
// Shared definitions for the synchroniser/filter bank.
//   MIN_STAGES, MIN_FILTER : smallest legal chain depth and filter length.
//   cnt_width()            : width of a filter counter that must count up to
//                            FILTER_CYCLES-1, never narrower than one bit.
package sync_pkg;

  localparam int MIN_STAGES = 2;
  localparam int MIN_FILTER = 1;

  function automatic int cnt_width(input int filter_cycles);
    return (filter_cycles <= 1) ? 1 : $clog2(filter_cycles);
  endfunction

endpackage

// File: rtl/sync_filter_bank_channel.sv
// One synchroniser channel: flop chain, stability filter and edge register.
// Ports:
//   clk, reset   : clock and asynchronous active-high reset
//   async_in     : asynchronous level input
//   sync_out     : filtered, synchronised level
//   rise_pulse   : one-cycle pulse when sync_out goes 0->1
//   fall_pulse   : one-cycle pulse when sync_out goes 1->0
//   change_d     : next-cycle value of (rise_pulse | fall_pulse), lets the
//                  parent register its OR in the same cycle as the pulses
module sync_filter_channel
  import sync_pkg::*;
#(
  parameter int   STAGES        = 2,
  parameter int   FILTER_CYCLES = 3,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic change_d
);

  localparam int            CW       = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  // Only stage_q[0] may go metastable; keep the chain intact and packed.
  (* ASYNC_REG = "TRUE", keep = "true" *) logic [STAGES-1:0] stage_q;

  logic          sample;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_q, sync_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  assign sample = stage_q[STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= {STAGES{RST_VAL}};
      cnt_q   <= '0;
      sync_q  <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], async_in};
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // A differing sample must persist FILTER_CYCLES consecutive cycles; any
  // matching cycle discards the partial count.
  always_comb begin
    cnt_d  = cnt_q;
    sync_d = sync_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sample == sync_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      sync_d = sample;
      rise_d = sample;
      fall_d = ~sample;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign change_d   = rise_d | fall_d;
  assign sync_out   = sync_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel synchroniser with per-channel glitch filter and edge pulses.
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   async_in    : CHANNELS asynchronous level inputs
//   sync_out    : CHANNELS filtered, synchronised levels
//   rise_pulse  : CHANNELS one-cycle 0->1 pulses
//   fall_pulse  : CHANNELS one-cycle 1->0 pulses
//   any_change  : registered OR of all pulses, coincident with them
module sync_filter_bank
  import sync_pkg::*;
#(
  parameter int                  CHANNELS      = 4,
  parameter int                  STAGES        = 2,
  parameter int                  FILTER_CYCLES = 3,
  parameter logic [CHANNELS-1:0] RESET_VALUE   = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("sync_filter_bank: CHANNELS must be >= 1");
  end
  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("sync_filter_bank: STAGES must be >= %0d", MIN_STAGES);
  end
  if (FILTER_CYCLES < MIN_FILTER) begin : g_bad_filter
    $error("sync_filter_bank: FILTER_CYCLES must be >= %0d", MIN_FILTER);
  end

  logic [CHANNELS-1:0] change_d;
  logic                any_change_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sync_filter_channel #(
      .STAGES        (STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RST_VAL       (RESET_VALUE[i])
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .async_in   (async_in[i]),
      .sync_out   (sync_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .change_d   (change_d[i])
    );
  end

  // Built from the channels' next-state pulses so it lines up with them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= |change_d;
    end
  end

  assign any_change = any_change_q;

endmodule
